// File: rtl/graphics_pkg.sv
// Shared graphics types: fp32 constants, column/matrix containers and the
// column-loader state encoding.
package graphics_pkg;

  localparam logic [31:0] FP32_ONE = 32'h3F800000;

  typedef logic [3:0][31:0] col_t;
  typedef col_t mat_t [4];

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    SEND
  } loader_state_t;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/matrix_col_loader.sv
// Column-load transmitter: collects a column-major 4x4 fp32 matrix, holds vertex
// issue while the shader drains, then strobes columns 0..3. Optional input byte
// reversal with MATRIX_LOADER_BYTE_SWAP_EN.
module matrix_col_loader
  import graphics_pkg::*;
#(
  parameter int DRAIN_CYCLES = 25
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             word_valid_in,
  input  logic [31:0]      word_in,
  input  logic             abort_in,
  output logic             word_ready_out,
  output logic             hold_out,
  output logic             col_set_out,
  output logic [3:0][31:0] col_out,
  output logic             done_out
);

  localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int CNT_W     = $clog2(DRAIN_EFF + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_EFF - 1);

  loader_state_t    state, state_d;
  logic [3:0]       idx, idx_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       col_idx, col_idx_d;
  logic             col_set_d, done_d, hold_d, wr_en;
  col_t             col_out_d;
  logic [31:0]      wr_data;
  mat_t             mat;

`ifdef MATRIX_LOADER_BYTE_SWAP_EN
  assign wr_data = byte_swap(word_in);
`else
  assign wr_data = word_in;
`endif

  assign word_ready_out = (state == COLLECT);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    col_idx_d = col_idx;
    col_set_d = 1'b0;
    col_out_d = col_out;
    done_d    = 1'b0;
    hold_d    = hold_out;
    wr_en     = 1'b0;
    case (state)
      COLLECT: begin
        if (abort_in) begin
          idx_d = '0;
        end else if (word_valid_in) begin
          wr_en = 1'b1;
          idx_d = idx + 4'd1;
          if (idx == 4'd15) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
            hold_d  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          state_d   = SEND;
          col_idx_d = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      SEND: begin
        // Four strobes back to back; the shader's column index has no backpressure.
        if (col_idx[2]) begin
          state_d = COLLECT;
          done_d  = 1'b1;
          hold_d  = 1'b0;
          idx_d   = '0;
        end else begin
          col_set_d = 1'b1;
          col_out_d = mat[col_idx[1:0]];
          col_idx_d = col_idx + 3'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= COLLECT;
      idx         <= '0;
      cnt         <= '0;
      col_idx     <= '0;
      col_set_out <= 1'b0;
      col_out     <= '0;
      done_out    <= 1'b0;
      hold_out    <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      cnt         <= cnt_d;
      col_idx     <= col_idx_d;
      col_set_out <= col_set_d;
      col_out     <= col_out_d;
      done_out    <= done_d;
      hold_out    <= hold_d;
    end
  end

  // NOTE: the matrix buffer is reset on purpose so a reload after reset never
  // exposes stale elements; storage arrays normally skip reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < 4; c++) mat[c] <= '0;
    end else if (wr_en) begin
      mat[idx[3:2]][idx[1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_matrix_col_loader.sv
// Directed bench for matrix_col_loader: load, gapped load, abort, held valid,
// reset during transmit and the byte-swap build option.
module tb_matrix_col_loader;
  import graphics_pkg::*;

  localparam int D = 25;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic             word_valid_in = 1'b0;
  logic [31:0]      word_in = '0;
  logic             abort_in = 1'b0;
  logic             word_ready_out, hold_out, col_set_out, done_out;
  logic [3:0][31:0] col_out;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] seq_w [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
  logic [31:0] ident_w [16];

  always #5 clk_in = ~clk_in;

  matrix_col_loader #(.DRAIN_CYCLES(D)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .word_valid_in (word_valid_in),
    .word_in       (word_in),
    .abort_in      (abort_in),
    .word_ready_out(word_ready_out),
    .hold_out      (hold_out),
    .col_set_out   (col_set_out),
    .col_out       (col_out),
    .done_out      (done_out)
  );

  function automatic mat_t to_mat(input logic [31:0] w [16]);
    mat_t m;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[c][r] = w[4*c + r];
    return m;
  endfunction

  task automatic push_word(input logic [31:0] w);
    word_valid_in = 1'b1;
    word_in       = w;
    @(negedge clk_in);
    word_valid_in = 1'b0;
  endtask

  task automatic push_matrix(input logic [31:0] w [16], input int gap);
    for (int k = 0; k < 16; k++) begin
      push_word(w[k]);
      if (k < 15) repeat (gap) @(negedge clk_in);
    end
  endtask

  // Called on the negedge right after the 16th word was accepted.
  task automatic expect_transmit(input mat_t m, input string tag);
    int n = 0;
    vectors++;
    if (hold_out !== 1'b1 || word_ready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL %s hold_after_last: hold=%b ready=%b, required hold=1 ready=0",
               tag, hold_out, word_ready_out);
    end
    while (col_set_out !== 1'b1 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    vectors++;
    if (n != D + 1) begin
      miscompares++;
      $display("FAIL %s strobe_latency: got %0d cycles, required %0d", tag, n, D + 1);
      if (n >= 200) return;
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (col_set_out !== 1'b1 || hold_out !== 1'b1 || col_out !== m[c]) begin
        miscompares++;
        $display("FAIL %s col%0d: set=%b hold=%b data=%h, required set=1 hold=1 data=%h",
                 tag, c, col_set_out, hold_out, col_out, m[c]);
      end
      @(negedge clk_in);
    end
    vectors++;
    if (col_set_out !== 1'b0 || done_out !== 1'b1 || hold_out !== 1'b0 || word_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done: set=%b done=%b hold=%b ready=%b, required 0 1 0 1",
               tag, col_set_out, done_out, hold_out, word_ready_out);
    end
    @(negedge clk_in);
    vectors++;
    if (done_out !== 1'b0 || col_set_out !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_pulse_end: done=%b set=%b, required 0 0", tag, done_out, col_set_out);
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    vectors++;
    if (word_ready_out !== 1'b1 || hold_out !== 1'b0 || col_set_out !== 1'b0 ||
        col_out !== '0 || done_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b hold=%b set=%b col=%h done=%b, required 1 0 0 0 0",
               word_ready_out, hold_out, col_set_out, col_out, done_out);
    end
  endtask

  task automatic test_load();
    push_matrix(seq_w, 0);
    expect_transmit(to_mat(seq_w), "load");
  endtask

  task automatic test_gapped();
    push_matrix(seq_w, 2);
    expect_transmit(to_mat(seq_w), "gapped");
  endtask

  task automatic test_abort();
    for (int k = 0; k < 7; k++) push_word(seq_w[k]);
    abort_in      = 1'b1;
    word_valid_in = 1'b1;
    word_in       = 32'hFFFF_FFFF;
    @(negedge clk_in);
    abort_in      = 1'b0;
    word_valid_in = 1'b0;
    push_matrix(ident_w, 0);
    expect_transmit(to_mat(ident_w), "abort_identity");
  endtask

  task automatic test_held_valid();
    logic [31:0] w2 [16];
    for (int k = 0; k < 15; k++) push_word(seq_w[k]);
    word_valid_in = 1'b1;
    word_in       = seq_w[15];
    @(negedge clk_in);
    word_in = 32'hDEAD_BEEF;
    expect_transmit(to_mat(seq_w), "held_valid_first");
    // DEADBEEF is taken once, as word 0, on the first COLLECT cycle.
    w2 = seq_w;
    w2[0] = 32'hDEAD_BEEF;
    for (int k = 1; k < 16; k++) push_word(w2[k]);
    expect_transmit(to_mat(w2), "held_valid_second");
  endtask

  task automatic test_reset_mid_send();
    int n = 0;
    int strobes = 0;
    push_matrix(seq_w, 0);
    while (col_set_out !== 1'b1 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    vectors++;
    if (col_set_out !== 1'b0 || hold_out !== 1'b0 || col_out !== '0 ||
        done_out !== 1'b0 || word_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_send: set=%b hold=%b col=%h done=%b ready=%b, required 0 0 0 0 1",
               col_set_out, hold_out, col_out, done_out, word_ready_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (40) begin
      @(negedge clk_in);
      if (col_set_out === 1'b1) strobes++;
    end
    vectors++;
    if (strobes != 0) begin
      miscompares++;
      $display("FAIL reset_no_strobes: got %0d strobes, required 0", strobes);
    end
    push_matrix(ident_w, 0);
    expect_transmit(to_mat(ident_w), "after_reset");
  endtask

  task automatic test_byte_swap();
    logic [31:0] w [16];
    logic [31:0] e [16];
    for (int k = 0; k < 16; k++) begin
      w[k] = 32'h0;
      e[k] = 32'h0;
    end
    w[0] = 32'h0000803F;
    w[5] = 32'h12345678;
`ifdef MATRIX_LOADER_BYTE_SWAP_EN
    e[0] = 32'h3F800000;
    e[5] = 32'h78563412;
`else
    e[0] = 32'h0000803F;
    e[5] = 32'h12345678;
`endif
    push_matrix(w, 0);
    expect_transmit(to_mat(e), "byte_swap");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) ident_w[k] = (k % 5 == 0) ? FP32_ONE : 32'h0;
    test_reset();
    test_load();
    test_gapped();
    test_abort();
    test_held_valid();
    test_reset_mid_send();
    test_byte_swap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
